uart_tx_scheduler: RTL and testbench

Shares the single serial transmitter among NUM_REQ byte-producing requesters using round-robin arbitration. For each frame it latches the requester's byte, pulses the transmitter's load, and tracks the transmitter's busy flag (tx_state) through start and completion. It then enforces an inter-frame gap before serving the next requester. It sits between the requester logic and the transmitter; the receiver side is unaffected.

---
 rtl/uart_tx_scheduler_pkg.sv | 21 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 40 ++++
 rtl/uart_tx_scheduler.sv | 118 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Holds the FSM state encoding and the default frame timing.
package uart_tx_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_START = 3'd2,
    SENDING    = 3'd3,
    GAP        = 3'd4
  } state_t;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_GAP_CYCLES    = 10;
  localparam int DEF_START_TIMEOUT = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational rotating-priority picker: the first set request strictly
// after i_ptr (with wrap) wins, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_sh;
  logic [IDX_W:0]       w_sh_amt;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotate so bit k of w_rot is requester (ptr+1+k) mod NUM_REQ.
  assign w_dbl    = {i_req, i_req};
  assign w_sh_amt = {1'b0, i_ptr} + (IDX_W+1)'(1);
  assign w_sh     = w_dbl >> w_sh_amt;
  assign w_rot    = w_sh[NUM_REQ-1:0];

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + 1 + k) % NUM_REQ);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign o_onehot[gi] = o_any && (o_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters:
// latch byte, pulse load, follow tx_state through the frame, then hold an idle gap.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      tx_load,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_state,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, START_TIMEOUT)) + 1;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_ptr;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  r_done;
  logic [DATA_W-1:0]   r_tx_data;

  logic [NUM_REQ-1:0]  w_onehot;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= IDX_W'(NUM_REQ - 1);
      r_grant   <= '0;
      r_done    <= '0;
      r_tx_data <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant   <= w_onehot;
            r_tx_data <= w_bytes[w_idx];
            r_ptr     <= w_idx;
            r_state   <= LOAD;
          end
        end
        LOAD: begin
          r_cnt   <= '0;
          r_state <= WAIT_START;
        end
        WAIT_START: begin
          if (tx_state) begin
            r_state <= SENDING;
          end else if (r_cnt == CNT_W'(START_TIMEOUT - 1)) begin
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        SENDING: begin
          // The grant is still one-hot on the owner, so it doubles as the done vector.
          if (!tx_state) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign tx_data     = r_tx_data;
  assign tx_load     = (r_state == LOAD);
  assign busy        = (r_state != IDLE);
  assign err_timeout = (r_state == WAIT_START) && !tx_state &&
                       (r_cnt == CNT_W'(START_TIMEOUT - 1));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple transmitter model that
// stays busy for FRAME clocks after each load and captures the byte at frame end.
module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int GAP   = 10;
  localparam int STO   = 16;
  localparam int FRAME = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     grant, done;
  logic              tx_load;
  logic [DW-1:0]     tx_data;
  logic              tx_state;
  logic              busy, err_timeout;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int prev_done = -1;

  logic       tx_connect = 1'b1;
  logic       m_busy;
  int         m_cnt;
  logic [7:0] rx_byte;

  uart_tx_scheduler #(
    .NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAP), .START_TIMEOUT(STO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .done(done), .tx_load(tx_load), .tx_data(tx_data),
    .tx_state(tx_state), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter stand-in
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      rx_byte <= 8'h00;
    end else if (!m_busy && tx_load && tx_connect) begin
      m_busy  <= 1'b1;
      m_cnt   <= FRAME;
      rx_byte <= 8'h00;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        rx_byte <= tx_data;
      end
      m_cnt <= m_cnt - 1;
    end
  end
  assign tx_state = m_busy;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    prev_done = -1;
    @(negedge clk);
  endtask

  task automatic wait_load(output bit ok);
    int t;
    t = 0;
    while (!tx_load && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = tx_load;
  endtask

  task automatic run_frame(input int idx, input logic [7:0] b, input logic keep, input string nm);
    int t;
    int ld;
    bit ok;
    logic [NR-1:0] exp_oh;
    exp_oh = NR'(1) << idx;
    wait_load(ok);
    check({nm, " load"}, 32'(tx_load), 32'd1);
    if (!ok) return;
    ld = cyc;
    check({nm, " grant"}, 32'(grant), 32'(exp_oh));
    check({nm, " tx_data"}, 32'(tx_data), 32'(b));
    if (prev_done >= 0) check({nm, " done->load"}, 32'(ld - prev_done), 32'(GAP + 1));
    @(negedge clk);
    check({nm, " load pulse"}, 32'(tx_load), 32'd0);
    t = 0;
    while (done == '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({nm, " done"}, 32'(done), 32'(exp_oh));
    prev_done = cyc;
    if (!keep) req[idx] = 1'b0;
    @(negedge clk);
    check({nm, " done pulse"}, 32'(done), 32'd0);
    check({nm, " rx byte"}, 32'(rx_byte), 32'(b));
    $display("frame %s: requester %0d byte %02h received %02h", nm, idx, b, rx_byte);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  keep;
    int          n;
    logic [11:0] ord;   // 2 bits per frame, frame 0 in the LSBs
  } vec_t;

  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ld, t, nd;
    logic [NR-1:0] dv;

    vt[0] = '{req: 4'b0100, data: 32'h009D_0000, keep: 4'b0000, n: 1, ord: 12'h002};
    vt[1] = '{req: 4'b1111, data: 32'h4433_2211, keep: 4'b0000, n: 4, ord: 12'h0E4};
    vt[2] = '{req: 4'b1001, data: 32'hA500_005A, keep: 4'b1001, n: 6, ord: 12'hCCC};
    vt[3] = '{req: 4'b0110, data: 32'h00C3_3C00, keep: 4'b0000, n: 2, ord: 12'h009};

    do_reset();
    check("reset outputs", 32'({grant, done, tx_load, busy, err_timeout}), 32'd0);

    for (int i = 0; i < 4; i++) begin
      logic [11:0] ord;
      logic [31:0] dat;
      do_reset();
      ord      = vt[i].ord;
      dat      = vt[i].data;
      req_data = dat;
      req      = vt[i].req;
      for (int f = 0; f < vt[i].n; f++) begin
        int idx;
        idx = int'(ord[f*2 +: 2]);
        run_frame(idx, dat[idx*8 +: 8], vt[i].keep[idx], $sformatf("v%0d f%0d", i, f));
      end
      req = '0;
      t = 0;
      while (busy && t < 100) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("v%0d idle", i), 32'(busy), 32'd0);
    end

    // Transmitter disconnected: timeout, then normal service resumes
    do_reset();
    tx_connect = 1'b0;
    req_data   = 32'h0000_4500;
    req        = 4'b0010;
    wait_load(ok);
    ld = cyc;
    check("to grant", 32'(grant), 32'h2);
    req = '0;
    nd = 0;
    t = 0;
    while (!err_timeout && t < 100) begin
      @(negedge clk);
      if (done != '0) nd++;
      t++;
    end
    check("to err", 32'(err_timeout), 32'd1);
    check("to delay", 32'(cyc - ld), 32'(STO));
    @(negedge clk);
    if (done != '0) nd++;
    check("to grant clr", 32'(grant), 32'd0);
    check("to err pulse", 32'(err_timeout), 32'd0);
    check("to no done", 32'(nd), 32'd0);
    $display("timeout: load at %0d, err after %0d clocks", ld, STO);
    tx_connect = 1'b1;
    prev_done  = -1;
    req_data   = 32'h00AB_0000;
    req        = 4'b0100;
    run_frame(2, 8'hAB, 1'b0, "after to");

    // Reset while SENDING clears outputs asynchronously
    do_reset();
    req_data = 32'h0000_7700;
    req      = 4'b0100;
    req_data = 32'h0077_0000;
    wait_load(ok);
    req = '0;
    repeat (5) @(negedge clk);
    check("mid busy", 32'({busy, tx_state}), 32'h3);
    #2 reset = 1'b1;
    #1 check("async clr", 32'({grant, tx_load, done, busy}), 32'd0);
    $display("reset mid-frame at cycle %0d", cyc);
    @(negedge clk);
    reset      = 1'b0;
    prev_done  = -1;
    req_data   = 32'hD400_E100;
    req        = 4'b1010;
    run_frame(1, 8'hE1, 1'b0, "post rst a");
    run_frame(3, 8'hD4, 1'b0, "post rst b");

    // req and data withdrawn one cycle after grant
    do_reset();
    req_data = 32'h7E00_0000;
    req      = 4'b1000;
    wait_load(ok);
    check("drop grant", 32'(grant), 32'h8);
    @(negedge clk);
    req      = '0;
    req_data = 32'hFFFF_FFFF;
    nd = 0;
    dv = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done != '0) begin
        nd++;
        dv = done;
      end
    end
    check("drop done cnt", 32'(nd), 32'd1);
    check("drop done", 32'(dv), 32'h8);
    check("drop rx", 32'(rx_byte), 32'h7E);
    $display("frame drop: requester 3 byte 7e received %02h", rx_byte);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
